// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the data-memory write path: store entry layout,
// RV32I store funct3 codes, alignment and size decode.
package riscv_mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [2:0]        nbytes;
  } store_entry_t;

  typedef enum logic {IDLE, WRITE} drain_state_t;

  // Unknown funct3 codes report as not aligned so one check covers legality.
  function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_SB:   return 1'b1;
      F3_SH:   return !addr_lo[0];
      F3_SW:   return addr_lo == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] nbytes_of(input logic [2:0] funct3);
    case (funct3)
      F3_SH:   return 3'd2;
      F3_SW:   return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/store_write_unit_fifo.sv
// Synchronous DEPTH-entry store buffer; pointers carry a wrap bit to tell full from empty.
module store_fifo
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  store_entry_t din,
  output store_entry_t dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  store_entry_t   mem [DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = wr_ptr == rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/store_write_unit.sv
// Store write unit: legality check, store buffer and byte-serial drain to the
// byte-wide data-memory write port, little-endian, with registered outputs.
module store_write_unit
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [2:0]            st_funct3,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  output logic                  st_misalign,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [BYTE_WIDTH-1:0] mem_wdata,
  output logic                  busy
);

  logic         accept, legal, full, empty, pop;
  store_entry_t din, dout, cur;
  drain_state_t state, state_nxt;
  logic [1:0]   k, k_nxt, last;

  logic                  wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [BYTE_WIDTH-1:0] wdata_d;

  assign st_ready = !full;
  assign accept   = st_valid && st_ready;
  assign legal    = is_aligned(st_funct3, st_addr[1:0]);
  assign din      = '{addr: st_addr, data: st_data, nbytes: nbytes_of(st_funct3)};
  assign busy     = !empty || (state != IDLE);
  assign last     = 2'(cur.nbytes - 3'd1);

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept && legal),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      k     <= '0;
      cur   <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      if (pop) cur <= dout;
    end
  end

  // On the last byte the next entry is popped directly, so words stream without a bubble.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          k_nxt     = '0;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (k == last) begin
          k_nxt = '0;
          if (!empty) pop = 1'b1;
          else        state_nxt = IDLE;
        end else begin
          k_nxt = k + 2'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_en_d = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    if (state == WRITE) begin
      wr_en_d = 1'b1;
      addr_d  = cur.addr + ADDR_WIDTH'(k);
      wdata_d = cur.data[{k, 3'b000} +: BYTE_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_wr_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      st_misalign <= 1'b0;
    end else begin
      mem_wr_en   <= wr_en_d;
      mem_addr    <= addr_d;
      mem_wdata   <= wdata_d;
      st_misalign <= accept && !legal;
    end
  end

endmodule

// File: tb/tb_store_write_unit.sv
// Directed bench for store_write_unit: a byte-stream model checked every cycle,
// plus literal expectations for latency, ordering, gaps and reset behaviour.
module tb_store_write_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [2:0]  st_funct3;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_misalign;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;

  store_write_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
    .st_funct3(st_funct3), .st_addr(st_addr), .st_data(st_data),
    .st_misalign(st_misalign), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] a; logic [7:0] d;} wr_t;

  wr_t   exp_q[$];
  int    pass_cnt = 0, total_cnt = 0;
  int    cyc = 0, acc_cyc = 0;
  bit    started = 0, mis_exp = 0, nr_seen = 0;
  int    wr_count = 0, mis_count = 0, first_cyc = 0, last_cyc = 0;
  logic [31:0] first_a, last_a;
  logic [7:0]  first_d, last_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  // Model: a legal store expands into its byte writes, in order; anything else yields a pulse.
  always @(posedge clk) begin
    cyc++;
    started = 1;
    mis_exp = 0;
    if (!rst_n) exp_q.delete();
    else if (st_valid && st_ready) begin
      int n;
      acc_cyc = cyc;
      n = (st_funct3 == 3'd0) ? 1 : (st_funct3 == 3'd1) ? 2 : (st_funct3 == 3'd2) ? 4 : 0;
      if (n != 0 && (st_addr % n) == 0) begin
        for (int i = 0; i < n; i++) begin
          wr_t w;
          w.a = st_addr + i;
          w.d = 8'((st_data >> (8 * i)) & 32'hFF);
          exp_q.push_back(w);
        end
      end else mis_exp = 1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("misalign", {31'd0, st_misalign}, {31'd0, mis_exp});
      if (st_valid && !st_ready) nr_seen = 1;
      if (st_misalign) mis_count++;
      if (mem_wr_en) begin
        if (exp_q.size() == 0) chk("unexpected_write", {31'd0, mem_wr_en}, 32'd0);
        else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", mem_addr, e.a);
          chk("wr_data", {24'd0, mem_wdata}, {24'd0, e.d});
        end
        if (wr_count == 0) begin
          first_cyc = cyc; first_a = mem_addr; first_d = mem_wdata;
        end
        last_cyc = cyc; last_a = mem_addr; last_d = mem_wdata;
        wr_count++;
      end else begin
        chk("idle_addr", mem_addr, 32'd0);
        chk("idle_data", {24'd0, mem_wdata}, 32'd0);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    wr_count = 0; mis_count = 0; nr_seen = 0;
  endtask

  task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    bit ok;
    st_valid = 1; st_funct3 = f3; st_addr = a; st_data = d;
    for (int t = 0; t < 50; t++) begin
      ok = st_ready;
      step();
      if (ok) return;
    end
    chk("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) step();
    chk("drain_timeout", exp_q.size(), 32'd0);
    step();
  endtask

  initial begin
    rst_n = 0; st_valid = 1; st_funct3 = 3'd2; st_addr = 32'h0; st_data = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1; st_valid = 0;
    step();
    chk("rst_ready", {31'd0, st_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_writes", wr_count, 32'd0);

    // single SW
    clr();
    send(3'd2, 32'h10, 32'hDEAD_BEEF);
    st_valid = 0;
    wait_drain();
    chk("sw_latency", first_cyc - acc_cyc, 32'd2);
    chk("sw_count", wr_count, 32'd4);
    chk("sw_span", last_cyc - first_cyc, 32'd3);
    chk("sw_first_a", first_a, 32'h10);
    chk("sw_first_d", {24'd0, first_d}, 32'hEF);
    chk("sw_last_a", last_a, 32'h13);
    chk("sw_last_d", {24'd0, last_d}, 32'hDE);

    // SB then SH back to back
    clr();
    send(3'd0, 32'h23, 32'h1234_56AB);
    send(3'd1, 32'h40, 32'h0000_CAFE);
    st_valid = 0;
    wait_drain();
    chk("sbsh_count", wr_count, 32'd3);
    chk("sbsh_span", last_cyc - first_cyc, 32'd2);
    chk("sbsh_first", {first_a[23:0], first_d}, 32'h0000_23AB);
    chk("sbsh_last", {last_a[23:0], last_d}, 32'h0000_41CA);

    // rejected requests
    clr();
    send(3'd1, 32'h41, 32'h1111_2222);
    chk("rej_busy0", {31'd0, busy}, 32'd0);
    send(3'd2, 32'h42, 32'h3333_4444);
    chk("rej_busy1", {31'd0, busy}, 32'd0);
    send(3'd3, 32'h0, 32'h5555_6666);
    st_valid = 0;
    chk("rej_busy2", {31'd0, busy}, 32'd0);
    repeat (4) step();
    chk("rej_pulses", mis_count, 32'd3);
    chk("rej_writes", wr_count, 32'd0);
    chk("rej_busy3", {31'd0, busy}, 32'd0);

    // burst of 6 SWs overflows the 4-entry buffer
    clr();
    for (int i = 0; i < 6; i++)
      send(3'd2, 32'h100 + 32'(4 * i), {8'(i + 1), 8'hB1, 8'hC2, 8'(8'h10 + i)});
    st_valid = 0;
    wait_drain();
    chk("burst_backpressure", {31'd0, nr_seen}, 32'd1);
    chk("burst_count", wr_count, 32'd24);
    chk("burst_span", last_cyc - first_cyc, 32'd23);
    chk("burst_first", {first_a[23:0], first_d}, 32'h0001_0010);
    chk("burst_last", {last_a[23:0], last_d}, 32'h0001_1706);
    step();
    chk("burst_busy", {31'd0, busy}, 32'd0);

    // reset during the second byte of an SW
    clr();
    send(3'd2, 32'h200, 32'h1122_3344);
    st_valid = 0;
    for (int t = 0; t < 20 && wr_count < 2; t++) step();
    chk("mid_second_byte", {last_a[23:0], last_d}, 32'h0002_0133);
    rst_n = 0;
    step();
    rst_n = 1;
    chk("mid_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("mid_ready", {31'd0, st_ready}, 32'd1);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    repeat (6) step();
    chk("mid_writes", wr_count, 32'd2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
